// File: rtl/ahb2apb_bridge_mslv.sv
// ahb2apb_bridge_mslv
//   AHB-Lite slave to APB4 master bridge that fans one AHB port out to
//   NUM_SLV APB slaves. The slave index is taken from Haddr[SLV_LSB +: SEL_W].
//   One transfer is in flight at a time. APB wait states stretch the AHB data
//   phase. Slave errors, unmapped indices, oversize transfers and ACCESS
//   timeouts all end in a two-cycle AHB ERROR response.
//
// Ports
//   clock, Hresetn               : clock and synchronous active-low reset
//   Htrans, Hsize, Hreadyin,
//   Haddr, Hwrite, Hwdata, Hburst : AHB address/data phase inputs (Hburst unused)
//   Hrdata, Hresp, Hreadyout     : AHB response (combinational from state)
//   Prdata, Pready, Pslverr      : APB response from the selected slave
//   Pselx, Penable, Pwrite,
//   Paddr, Pwdata, Pstrb         : APB request (registered except Pwdata)
//   dbg_state                    : current FSM state, for observation only
//
// Handshake: an AHB transfer is accepted in any cycle where Hreadyin=1,
// Hreadyout=1 and Htrans is NONSEQ or SEQ. The APB side completes a transfer
// in an ACCESS cycle with Pready=1; Pslverr is only meaningful in that cycle.
module ahb2apb_bridge_mslv #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  Hresetn,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hsize,
    input  logic                  Hreadyin,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic                  Hwrite,
    input  logic [DATA_W-1:0]     Hwdata,
    input  logic [2:0]            Hburst,
    output logic [DATA_W-1:0]     Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    output logic [NUM_SLV-1:0]    Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata,
    output logic [DATA_W/8-1:0]   Pstrb,
    output logic [2:0]            dbg_state
);

    localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q;
    logic [SEL_W-1:0]     idx_in;
    logic [SEL_W-1:0]     sel_idx;
    logic [DATA_W-1:0]    pwdata_q;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 valid;
    logic                 legal;
    logic                 capture;
    logic                 timed_out;
    logic                 unused_hburst;

    assign unused_hburst = ^Hburst;
    assign dbg_state     = state_q;

    // Contiguous byte strobes for a naturally aligned transfer: the lane
    // address is rounded down to the transfer size before the mask is placed.
    function automatic logic [STRB_W-1:0] calc_strb(input logic [2:0] size,
                                                    input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] s;
        int nbytes;
        int base;
        nbytes = 1 << int'(size);
        base   = int'(lane) & ~(nbytes - 1);
        s      = '0;
        for (int i = 0; i < STRB_W; i++) begin
            s[i] = (i >= base) && (i < base + nbytes);
        end
        return s;
    endfunction

    assign idx_in    = Haddr[SLV_LSB +: SEL_W];
    assign legal     = (int'(idx_in) < NUM_SLV) && (int'(Hsize) <= LANE_W);
    assign valid     = Hreadyin && Hreadyout && Htrans[1];
    assign timed_out = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT);
    assign sel_idx   = capture ? idx_in : idx_q;

    // AHB response is purely a function of state and the APB response.
    always_comb begin : p_ahb_out
        Hreadyout = 1'b1;
        Hresp     = RESP_OKAY;
        Hrdata    = '0;
        case (state_q)
            ST_SETUP:  Hreadyout = 1'b0;
            ST_ACCESS: begin
                Hreadyout = Pready && !Pslverr;
                Hrdata    = Prdata;
            end
            ST_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = RESP_ERROR;
            end
            ST_ERR2:   Hresp = RESP_ERROR;
            default:   ;
        endcase
    end

    always_comb begin : p_next
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (valid) begin
                    capture = 1'b1;
                    state_d = legal ? ST_SETUP : ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (Pready) begin
                    if (Pslverr) begin
                        state_d = ST_ERR1;
                    end else if (valid) begin
                        // Next address phase overlaps this completion cycle.
                        capture = 1'b1;
                        state_d = legal ? ST_SETUP : ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1:  state_d = ST_ERR2;
            default:  state_d = ST_IDLE;
        endcase
    end

    // APB request outputs are registered from the next state so they line up
    // with SETUP/ACCESS without any combinational path from AHB inputs.
    always_ff @(posedge clock) begin : p_regs
        if (!Hresetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            pwdata_q <= '0;
            wait_cnt <= '0;
            Pselx    <= '0;
            Penable  <= 1'b0;
            Pwrite   <= 1'b0;
            Paddr    <= '0;
            Pstrb    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                idx_q  <= idx_in;
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                Pstrb  <= (Hwrite && legal) ? calc_strb(Hsize, Haddr[LANE_W-1:0]) : '0;
            end
            if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
                Pselx <= NUM_SLV'(1) << sel_idx;
            end else begin
                Pselx <= '0;
            end
            Penable <= (state_d == ST_ACCESS);
            // Write data arrives in the AHB data phase, i.e. during SETUP.
            if (state_q == ST_SETUP && Pwrite) begin
                pwdata_q <= Hwdata;
            end
            if (capture) begin
                wait_cnt <= '0;
            end else if (state_q == ST_ACCESS && !Pready && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign Pwdata = (state_q == ST_SETUP && Pwrite) ? Hwdata : pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
module tb_ahb2apb_bridge_mslv;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_ERR1   = 3'd3;
  localparam logic [2:0] S_ERR2   = 3'd4;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        Hresetn;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  logic [31:0] a_hrdata, b_hrdata;
  logic [1:0]  a_hresp, b_hresp;
  logic        a_hreadyout, b_hreadyout;
  logic [3:0]  a_pselx;
  logic [2:0]  b_pselx;
  logic        a_penable, b_penable;
  logic        a_pwrite, b_pwrite;
  logic [31:0] a_paddr, b_paddr;
  logic [31:0] a_pwdata, b_pwdata;
  logic [3:0]  a_pstrb, b_pstrb;
  logic [2:0]  a_state, b_state;

  int n_tests = 0;
  int n_fail  = 0;

  ahb2apb_bridge_mslv #(.NUM_SLV(4), .TIMEOUT(4)) u_a (
    .clock(clock), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hburst(Hburst), .Hrdata(a_hrdata), .Hresp(a_hresp), .Hreadyout(a_hreadyout),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr), .Pselx(a_pselx),
    .Penable(a_penable), .Pwrite(a_pwrite), .Paddr(a_paddr), .Pwdata(a_pwdata),
    .Pstrb(a_pstrb), .dbg_state(a_state)
  );

  ahb2apb_bridge_mslv #(.NUM_SLV(3), .TIMEOUT(0)) u_b (
    .clock(clock), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hburst(Hburst), .Hrdata(b_hrdata), .Hresp(b_hresp), .Hreadyout(b_hreadyout),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr), .Pselx(b_pselx),
    .Penable(b_penable), .Pwrite(b_pwrite), .Paddr(b_paddr), .Pwdata(b_pwdata),
    .Pstrb(b_pstrb), .dbg_state(b_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    Hresetn  = 1'b0;
    Htrans   = 2'b00;
    Hsize    = 3'd0;
    Hburst   = 3'd0;
    Hreadyin = 1'b1;
    Haddr    = '0;
    Hwrite   = 1'b0;
    Hwdata   = '0;
    Prdata   = '0;
    Pready   = 1'b1;
    Pslverr  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    Hresetn = 1'b1;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    Htrans = 2'b10;
    Haddr  = addr;
    Hwrite = wr;
    Hsize  = size;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    Prdata = 32'hFFFF_FFFF;
    @(negedge clock);
    n_tests++; if (a_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", a_state, S_IDLE); end
    n_tests++; if (a_hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout: got %b expected 1", a_hreadyout); end
    n_tests++; if (a_hresp !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b expected 00", a_hresp); end
    n_tests++; if (a_hrdata !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata: got %h expected 0", a_hrdata); end
    n_tests++; if ({a_pselx, a_penable, a_pwrite} !== 6'b0) begin n_fail++; $display("FAIL rst_apb_ctl: got %b expected 000000", {a_pselx, a_penable, a_pwrite}); end
    n_tests++; if ({a_paddr, a_pwdata, a_pstrb} !== 68'h0) begin n_fail++; $display("FAIL rst_apb_data: got %h expected 0", {a_paddr, a_pwdata, a_pstrb}); end
  endtask

  task automatic test_write();
    do_reset();
    addr_phase(32'h0000_1004, 1'b1, 3'd2);
    @(negedge clock);
    n_tests++; if (a_hreadyout !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b expected 1", a_hreadyout); end
    next_cycle();
    Htrans = 2'b00;
    Hwdata = 32'hDEAD_BEEF;
    @(negedge clock);
    n_tests++; if (a_state !== S_SETUP) begin n_fail++; $display("FAIL wr_setup_state: got %0d expected %0d", a_state, S_SETUP); end
    n_tests++; if (a_pselx !== 4'b0010) begin n_fail++; $display("FAIL wr_setup_pselx: got %b expected 0010", a_pselx); end
    n_tests++; if (a_penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup_penable: got %b expected 0", a_penable); end
    n_tests++; if (a_hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_setup_hready: got %b expected 0", a_hreadyout); end
    n_tests++; if (a_pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_setup_pwdata: got %h expected deadbeef", a_pwdata); end
    n_tests++; if (a_pstrb !== 4'b1111) begin n_fail++; $display("FAIL wr_pstrb: got %b expected 1111", a_pstrb); end
    n_tests++; if ({a_paddr, a_pwrite} !== {32'h0000_1004, 1'b1}) begin n_fail++; $display("FAIL wr_paddr_pwrite: got %h/%b expected 00001004/1", a_paddr, a_pwrite); end
    next_cycle();
    Hwdata = 32'h0;
    @(negedge clock);
    n_tests++; if (a_state !== S_ACCESS) begin n_fail++; $display("FAIL wr_access_state: got %0d expected %0d", a_state, S_ACCESS); end
    n_tests++; if ({a_pselx, a_penable} !== 5'b00101) begin n_fail++; $display("FAIL wr_access_psel_pen: got %b expected 00101", {a_pselx, a_penable}); end
    n_tests++; if ({a_hreadyout, a_hresp} !== 3'b100) begin n_fail++; $display("FAIL wr_access_resp: got %b expected 100", {a_hreadyout, a_hresp}); end
    n_tests++; if (a_pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_access_pwdata_hold: got %h expected deadbeef", a_pwdata); end
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_state, a_pselx} !== {S_IDLE, 4'b0000}) begin n_fail++; $display("FAIL wr_done_idle: got %b expected %b", {a_state, a_pselx}, {S_IDLE, 4'b0000}); end
  endtask

  task automatic test_read_wait();
    logic [3:0] hr_pat;
    do_reset();
    Pready = 1'b0;
    Prdata = 32'h1234_5678;
    addr_phase(32'h0000_3008, 1'b0, 3'd2);
    hr_pat = '0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      Htrans = 2'b00;
      Pready = (i == 3);
      @(negedge clock);
      hr_pat[i] = a_hreadyout;
      if (i == 0) begin
        n_tests++; if (a_pselx !== 4'b1000) begin n_fail++; $display("FAIL rd_pselx: got %b expected 1000", a_pselx); end
        n_tests++; if (a_pstrb !== 4'b0000) begin n_fail++; $display("FAIL rd_pstrb: got %b expected 0000", a_pstrb); end
        n_tests++; if (a_hrdata !== 32'h0) begin n_fail++; $display("FAIL rd_setup_hrdata: got %h expected 0", a_hrdata); end
      end
    end
    n_tests++; if (hr_pat !== 4'b1000) begin n_fail++; $display("FAIL rd_hready_pattern: got %b expected 1000", hr_pat); end
    n_tests++; if (a_hrdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hrdata: got %h expected 12345678", a_hrdata); end
    n_tests++; if ({a_state, a_penable} !== {S_ACCESS, 1'b1}) begin n_fail++; $display("FAIL rd_access: got %b expected %b", {a_state, a_penable}, {S_ACCESS, 1'b1}); end
    next_cycle();
    @(negedge clock);
    n_tests++; if (a_hrdata !== 32'h0) begin n_fail++; $display("FAIL rd_idle_hrdata: got %h expected 0", a_hrdata); end
  endtask

  task automatic test_strobes();
    logic [31:0] addr_t [4];
    logic [2:0]  size_t [4];
    logic [3:0]  exp_t  [4];
    addr_t = '{32'h3, 32'h2, 32'h1, 32'h3};
    size_t = '{3'd0, 3'd1, 3'd0, 3'd1};
    exp_t  = '{4'b1000, 4'b1100, 4'b0010, 4'b1100};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      addr_phase(addr_t[k], 1'b1, size_t[k]);
      next_cycle();
      Htrans = 2'b00;
      @(negedge clock);
      n_tests++; if (a_pstrb !== exp_t[k]) begin n_fail++; $display("FAIL strb_%0d: got %b expected %b", k, a_pstrb, exp_t[k]); end
      next_cycle();
      next_cycle();
    end
  endtask

  task automatic test_slverr();
    do_reset();
    Pslverr = 1'b1;
    addr_phase(32'h0000_0000, 1'b1, 3'd2);
    next_cycle();
    Htrans = 2'b00;
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_state, a_pselx, a_hreadyout} !== {S_ACCESS, 4'b0001, 1'b0}) begin n_fail++; $display("FAIL slv_access: got %b expected %b", {a_state, a_pselx, a_hreadyout}, {S_ACCESS, 4'b0001, 1'b0}); end
    next_cycle();
    Pslverr = 1'b0;
    @(negedge clock);
    n_tests++; if (a_state !== S_ERR1) begin n_fail++; $display("FAIL slv_err1_state: got %0d expected %0d", a_state, S_ERR1); end
    n_tests++; if ({a_hresp, a_hreadyout} !== 3'b010) begin n_fail++; $display("FAIL slv_err1_resp: got %b expected 010", {a_hresp, a_hreadyout}); end
    n_tests++; if ({a_pselx, a_penable} !== 5'b0) begin n_fail++; $display("FAIL slv_err1_apb: got %b expected 00000", {a_pselx, a_penable}); end
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_state, a_hresp, a_hreadyout} !== {S_ERR2, 3'b011}) begin n_fail++; $display("FAIL slv_err2: got %b expected %b", {a_state, a_hresp, a_hreadyout}, {S_ERR2, 3'b011}); end
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_state, a_hresp} !== {S_IDLE, 2'b00}) begin n_fail++; $display("FAIL slv_idle: got %b expected %b", {a_state, a_hresp}, {S_IDLE, 2'b00}); end
  endtask

  task automatic test_decode_err();
    // Unmapped index on the 3-slave bridge; the 4-slave one takes it normally.
    do_reset();
    addr_phase(32'h0000_3000, 1'b1, 3'd2);
    next_cycle();
    Htrans = 2'b00;
    @(negedge clock);
    n_tests++; if ({b_state, b_hresp, b_hreadyout} !== {S_ERR1, 3'b010}) begin n_fail++; $display("FAIL unmap_err1: got %b expected %b", {b_state, b_hresp, b_hreadyout}, {S_ERR1, 3'b010}); end
    n_tests++; if ({b_pselx, b_penable} !== 4'b0) begin n_fail++; $display("FAIL unmap_no_psel: got %b expected 0000", {b_pselx, b_penable}); end
    n_tests++; if ({a_state, a_pselx} !== {S_SETUP, 4'b1000}) begin n_fail++; $display("FAIL unmap_ref_setup: got %b expected %b", {a_state, a_pselx}, {S_SETUP, 4'b1000}); end
    next_cycle();
    @(negedge clock);
    n_tests++; if ({b_state, b_hresp, b_hreadyout} !== {S_ERR2, 3'b011}) begin n_fail++; $display("FAIL unmap_err2: got %b expected %b", {b_state, b_hresp, b_hreadyout}, {S_ERR2, 3'b011}); end
    // Oversize transfer, then a new transfer accepted straight from ERR2.
    do_reset();
    addr_phase(32'h0000_1000, 1'b1, 3'd3);
    next_cycle();
    Htrans = 2'b00;
    @(negedge clock);
    n_tests++; if ({a_state, a_hresp} !== {S_ERR1, 2'b01}) begin n_fail++; $display("FAIL size_err1: got %b expected %b", {a_state, a_hresp}, {S_ERR1, 2'b01}); end
    n_tests++; if ({a_pselx, a_penable} !== 5'b0) begin n_fail++; $display("FAIL size_no_psel: got %b expected 00000", {a_pselx, a_penable}); end
    next_cycle();
    addr_phase(32'h0000_1004, 1'b1, 3'd2);
    @(negedge clock);
    n_tests++; if ({a_state, a_hreadyout} !== {S_ERR2, 1'b1}) begin n_fail++; $display("FAIL size_err2: got %b expected %b", {a_state, a_hreadyout}, {S_ERR2, 1'b1}); end
    next_cycle();
    Htrans = 2'b00;
    @(negedge clock);
    n_tests++; if ({a_state, a_pselx} !== {S_SETUP, 4'b0010}) begin n_fail++; $display("FAIL err2_b2b_setup: got %b expected %b", {a_state, a_pselx}, {S_SETUP, 4'b0010}); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout();
    int b_cnt;
    do_reset();
    Pready = 1'b0;
    addr_phase(32'h0000_2000, 1'b1, 3'd2);
    next_cycle();
    Htrans = 2'b00;
    @(negedge clock);
    n_tests++; if ({a_state, a_pselx} !== {S_SETUP, 4'b0100}) begin n_fail++; $display("FAIL to_setup: got %b expected %b", {a_state, a_pselx}, {S_SETUP, 4'b0100}); end
    b_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      @(negedge clock);
      if (i < 5) begin
        n_tests++; if ({a_state, a_penable, a_hreadyout} !== {S_ACCESS, 2'b10}) begin n_fail++; $display("FAIL to_wait_%0d: got %b expected %b", i, {a_state, a_penable, a_hreadyout}, {S_ACCESS, 2'b10}); end
      end else if (i == 5) begin
        n_tests++; if ({a_state, a_pselx, a_penable, a_hresp} !== {S_ERR1, 5'b0, 2'b01}) begin n_fail++; $display("FAIL to_err1: got %b expected %b", {a_state, a_pselx, a_penable, a_hresp}, {S_ERR1, 5'b0, 2'b01}); end
      end else if (i == 6) begin
        n_tests++; if ({a_state, a_hreadyout} !== {S_ERR2, 1'b1}) begin n_fail++; $display("FAIL to_err2: got %b expected %b", {a_state, a_hreadyout}, {S_ERR2, 1'b1}); end
      end
      if (b_state == S_ACCESS && b_penable && !b_hreadyout) b_cnt++;
    end
    n_tests++; if (b_cnt != 100) begin n_fail++; $display("FAIL nolimit_wait: got %0d expected 100", b_cnt); end
    next_cycle();
    Pready = 1'b1;
    Prdata = 32'h55AA_55AA;
    @(negedge clock);
    n_tests++; if ({b_hreadyout, b_hresp, b_hrdata} !== {3'b100, 32'h55AA_55AA}) begin n_fail++; $display("FAIL nolimit_done: got %h expected %h", {b_hreadyout, b_hresp, b_hrdata}, {3'b100, 32'h55AA_55AA}); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    addr_phase(32'h0000_1004, 1'b1, 3'd2);
    next_cycle();
    Htrans = 2'b00;
    Hwdata = 32'hA5A5_A5A5;
    next_cycle();
    addr_phase(32'h0000_3008, 1'b0, 3'd2);
    @(negedge clock);
    n_tests++; if ({a_state, a_hreadyout} !== {S_ACCESS, 1'b1}) begin n_fail++; $display("FAIL b2b_first_done: got %b expected %b", {a_state, a_hreadyout}, {S_ACCESS, 1'b1}); end
    next_cycle();
    Htrans = 2'b00;
    Prdata = 32'hCAFE_F00D;
    @(negedge clock);
    n_tests++; if ({a_state, a_pselx, a_penable, a_pwrite} !== {S_SETUP, 4'b1000, 2'b00}) begin n_fail++; $display("FAIL b2b_second_setup: got %b expected %b", {a_state, a_pselx, a_penable, a_pwrite}, {S_SETUP, 4'b1000, 2'b00}); end
    n_tests++; if (a_paddr !== 32'h0000_3008) begin n_fail++; $display("FAIL b2b_paddr: got %h expected 00003008", a_paddr); end
    n_tests++; if (a_pwdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL b2b_read_pwdata_hold: got %h expected a5a5a5a5", a_pwdata); end
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_hreadyout, a_hrdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL b2b_read_data: got %h expected %h", {a_hreadyout, a_hrdata}, {1'b1, 32'hCAFE_F00D}); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    Pready = 1'b0;
    Prdata = 32'hFFFF_FFFF;
    addr_phase(32'h0000_2005, 1'b1, 3'd0);
    next_cycle();
    Htrans = 2'b00;
    Hwdata = 32'h1122_3344;
    next_cycle();
    @(negedge clock);
    n_tests++; if ({a_state, a_pstrb} !== {S_ACCESS, 4'b0010}) begin n_fail++; $display("FAIL rmid_access: got %b expected %b", {a_state, a_pstrb}, {S_ACCESS, 4'b0010}); end
    Hresetn = 1'b0;
    next_cycle();
    @(negedge clock);
    n_tests++; if (a_state !== S_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d expected %0d", a_state, S_IDLE); end
    n_tests++; if ({a_hreadyout, a_hresp, a_hrdata} !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL rmid_ahb: got %h expected %h", {a_hreadyout, a_hresp, a_hrdata}, {3'b100, 32'h0}); end
    n_tests++; if ({a_pselx, a_penable, a_pwrite} !== 6'b0) begin n_fail++; $display("FAIL rmid_apb_ctl: got %b expected 000000", {a_pselx, a_penable, a_pwrite}); end
    n_tests++; if ({a_paddr, a_pwdata, a_pstrb} !== 68'h0) begin n_fail++; $display("FAIL rmid_apb_data: got %h expected 0", {a_paddr, a_pwdata, a_pstrb}); end
    next_cycle();
    Hresetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_strobes();
    test_slverr();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge_mslv.md
# ahb2apb_bridge_mslv

Parametrised AHB-Lite to APB4 bridge: one AHB slave port fanned out to NUM_SLV APB slaves selected by address decode. Adds APB wait states (Pready), slave errors (Pslverr → two-cycle AHB ERROR), write strobes, illegal-size/unmapped-address errors and a per-transfer timeout. Sits between the AHB interconnect and the APB peripheral cluster; one transfer outstanding at a time.

## Interface
- ADDR_W, 32, address width (AHB and APB)
- DATA_W, 32, data width; 32 or 64
- NUM_SLV, 4, APB slave count, 1..16
- SLV_LSB, 12, lowest Haddr bit of the slave index field (field width SEL_W = clog2(NUM_SLV), min 1)
- TIMEOUT, 16, max ACCESS cycles awaiting Pready; 0 disables

- clock  in  1  bridge clock, all logic on rising edge
- Hresetn  in  1  synchronous active-low reset
- Htrans  in  2  AHB transfer type
- Hsize  in  3  AHB transfer size
- Hreadyin  in  1  AHB previous-transfer-done
- Haddr  in  ADDR_W  AHB address
- Hwrite  in  1  AHB direction, 1 = write
- Hwdata  in  DATA_W  AHB write data (data phase)
- Hburst  in  3  ignored; bursts handled as singles
- Hrdata  out  DATA_W  AHB read data
- Hresp  out  2  00 OKAY, 01 ERROR
- Hreadyout  out  1  data phase done
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB ready (from selected slave)
- Pslverr  in  1  APB slave error
- Pselx  out  NUM_SLV  one-hot APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pstrb  out  DATA_W/8  APB byte strobes

## Operation
- Valid: Hreadyin=1, Hreadyout=1, Htrans ∈ {10 NONSEQ, 11 SEQ}. IDLE/BUSY ignored.
- On valid, register Haddr, Hwrite, Hsize, index idx = Haddr[SLV_LSB +: SEL_W].
- Decode error: idx ≥ NUM_SLV or Hsize > clog2(DATA_W/8) → ERR1, no APB activity.
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: Hreadyout=1; valid & legal → SETUP; valid & illegal → ERR1.
  - SETUP: Pselx[idx]=1, Penable=0, Hreadyout=0; always → ACCESS.
  - ACCESS: Pselx[idx]=1, Penable=1. Pready=1 & Pslverr=0 → Hreadyout=1, Hresp=OKAY; next: SETUP/ERR1 on new valid, else IDLE. Pready=1 & Pslverr=1 → Hreadyout=0, → ERR1. Pready=0 & wait count = TIMEOUT (TIMEOUT≠0) → ERR1, APB dropped.
  - ERR1: Hresp=ERROR, Hreadyout=0, Pselx=0 → ERR2.
  - ERR2: Hresp=ERROR, Hreadyout=1; new valid accepted as in IDLE; else → IDLE.
- Pwdata: Hwdata passthrough in SETUP, captured at end of SETUP, held in ACCESS. Read: Pwdata held.
- Pstrb (writes): Hsize-wide contiguous ones at byte lane Haddr[clog2(DATA_W/8)-1:0], aligned down to size. Reads: 0.
- Hrdata = Prdata while ACCESS, else 0.
- Paddr = captured Haddr, held until next capture.
- Wait counter: clears on SETUP entry, +1 per ACCESS cycle with Pready=0, saturates.

## Timing
- Reset (Hresetn=0 at edge): state IDLE, Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Pstrb=0, counter 0. Reset mid-transfer aborts APB immediately at that edge; no error reported.
- Zero-wait latency: address phase T0, SETUP T1, ACCESS T2 with Hreadyout=1 → data phase = 2 cycles.
- Each Pready=0 cycle adds one. Error response = ACCESS + ERR1 + ERR2.
- Back-to-back: address phase overlapping ACCESS-complete or ERR2 cycle enters SETUP next cycle; no IDLE bubble.
- Pselx, Penable, Paddr, Pwrite, Pstrb registered; Hreadyout/Hresp/Hrdata combinational from state and Pready/Pslverr/Prdata.

## Test plan
- Write Haddr=0x0000_1004, Hsize=2, Hwdata=0xDEAD_BEEF, Pready=1 → Pselx=0010, SETUP then ACCESS, Pwdata=0xDEADBEEF, Pstrb=1111, Hreadyout low 1 cycle, Hresp=00.
- Read Haddr=0x0000_3008, Pready low 2 ACCESS cycles, Prdata=0x1234_5678 → Pselx=1000, Hreadyout low 3 cycles, Hrdata=0x12345678 in completion cycle.
- Byte write Haddr=0x0000_0003, Hsize=0 → Pstrb=1000; halfword Haddr=0x2 → 1100.
- Pslverr=1 with Pready=1 → Hresp=01 for 2 cycles, Hreadyout 0 then 1, Pselx=0 in ERR1; NUM_SLV=3, Haddr=0x3000 → same error, no Pselx; Hsize=3 at DATA_W=32 → same.
- TIMEOUT=4, Pready held 0 → ERR1 after 4 ACCESS-wait cycles, Pselx/Penable drop; TIMEOUT=0 → waits indefinitely (check 100 cycles).
- Back-to-back write then read → second SETUP in cycle after first completion; Hresetn=0 during ACCESS → all outputs at reset values next cycle, state IDLE.
